// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg -- shared definitions for the execute stage.
//   * bus widths for the ADU->EXU and EXU->LSU bundles
//   * alu_op encodings
//   * FSM state encoding
//   * packed structs describing the field layout of both bundles (MSB first)
//   * is_shift_op() helper used by the iterative shifter
// -----------------------------------------------------------------------------
package exu_pkg;

    localparam int ADU_EXU_BUS_WIDTH = 233;
    localparam int EXU_LSU_BUS_WIDTH = 192;

    localparam logic [5:0] ALU_ADD = 6'b110000;
    localparam logic [5:0] ALU_SUB = 6'b110001;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exu_state_e;

    // Decoded bundle from the ADU, first member is the bus MSB.
    typedef struct packed {
        logic        res_from_compare;
        logic        compare_result;
        logic        excp_flush;
        logic        xret_flush;
        logic        break_signal;
        logic [31:0] snpc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rs2_value;
        logic [5:0]  alu_op;
        logic        res_from_mem;
        logic        res_from_csr;
        logic        gr_we;
        logic        csr_we;
        logic [3:0]  mem_re;
        logic [3:0]  mem_we;
        logic [4:0]  rd;
        logic        jmp_flag;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic [31:0] csr_value;
    } adu_bundle_t;

    // Full execute-result field list (224 bits). The LSU bus is only 192 bits
    // wide, so the bus carries the low EXU_LSU_BUS_WIDTH bits of this struct;
    // the flush/break flags and the upper part of snpc do not reach the LSU.
    typedef struct packed {
        logic        excp_flush;
        logic        xret_flush;
        logic        break_signal;
        logic [31:0] snpc;
        logic [31:0] wb_data;
        logic [31:0] alu_result;
        logic [31:0] rs2_value;
        logic        res_from_mem;
        logic        res_from_csr;
        logic        gr_we;
        logic        csr_we;
        logic [3:0]  mem_re;
        logic [3:0]  mem_we;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic [31:0] csr_value;
    } lsu_bundle_t;

    localparam int LSU_FULL_WIDTH = $bits(lsu_bundle_t);

    function automatic logic is_shift_op(input logic [5:0] op);
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRA: is_shift_op = 1'b1;
            default:                   is_shift_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_if.sv
// -----------------------------------------------------------------------------
// exu_if -- handshake and data signals between ADU, EXU and LSU.
//   adu_valid_i / adu_ready_o / adu_exu_bus_i : upstream bundle handshake
//   exu_lsu_bus_o / valid_o / lsu_ready_i     : downstream result handshake
//   redirect_o / redirect_pc_o                : one-cycle PC redirect
// Modports: slave = the EXU itself, master = the environment driving it.
// -----------------------------------------------------------------------------
interface exu_if;
    import exu_pkg::*;

    logic                         adu_valid_i;
    logic                         adu_ready_o;
    logic [ADU_EXU_BUS_WIDTH-1:0] adu_exu_bus_i;
    logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_o;
    logic                         valid_o;
    logic                         lsu_ready_i;
    logic                         redirect_o;
    logic [31:0]                  redirect_pc_o;

    modport slave (
        input  adu_valid_i, adu_exu_bus_i, lsu_ready_i,
        output adu_ready_o, exu_lsu_bus_o, valid_o, redirect_o, redirect_pc_o
    );

    modport master (
        output adu_valid_i, adu_exu_bus_i, lsu_ready_i,
        input  adu_ready_o, exu_lsu_bus_o, valid_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/exu_alu.sv
// -----------------------------------------------------------------------------
// exu_alu -- combinational ALU: add, sub, xor, or, and, barrel sll/srl/sra.
//   i_src1, i_src2 : operands (shift amount is i_src2[4:0])
//   i_alu_op       : operation code; unknown codes give 0
//   o_result       : 32-bit result, add/sub wrap modulo 2^32
// -----------------------------------------------------------------------------
module exu_alu
    import exu_pkg::*;
(
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    input  logic [5:0]  i_alu_op,
    output logic [31:0] o_result
);
    // Operation select
    always_comb begin
        o_result = 32'd0;
        case (i_alu_op)
            ALU_ADD: o_result = i_src1 + i_src2;
            ALU_SUB: o_result = i_src1 - i_src2;
            ALU_XOR: o_result = i_src1 ^ i_src2;
            ALU_OR:  o_result = i_src1 | i_src2;
            ALU_AND: o_result = i_src1 & i_src2;
            ALU_SLL: o_result = i_src1 << i_src2[4:0];
            ALU_SRL: o_result = i_src1 >> i_src2[4:0];
            ALU_SRA: o_result = 32'($signed(i_src1) >>> i_src2[4:0]);
            default: o_result = 32'd0;
        endcase
    end
endmodule

// File: rtl/exu.sv
// -----------------------------------------------------------------------------
// exu -- execute stage: captures a decoded bundle, computes the ALU result,
// and presents the execute-result bundle to the LSU with valid/ready.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   io    : exu_if.slave (ADU handshake, LSU handshake, PC redirect)
// Build option EXU_ITER_SHIFT_EN: when defined, sll/srl/sra are computed one
// bit per cycle in the SHIFT state; otherwise the ALU barrel shifter is used
// and every op completes in a single cycle.
// -----------------------------------------------------------------------------
module exu
    import exu_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    exu_if.slave  io
);
    exu_state_e  r_state;
    exu_state_e  w_next_state;
    adu_bundle_t r_bundle;
    adu_bundle_t w_in;
    logic [31:0] r_result;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_alu_result;
    logic        w_ready;
    logic        w_hs;
    logic        w_iter_start;
    logic        w_shift_last;
    logic [31:0] w_shift_step;
    logic        w_enter_done;
    logic        w_enter_jmp;
    logic [31:0] w_done_result;
    logic [31:0] w_wb_data;
    lsu_bundle_t w_out;
    logic        w_unused_bits;

    assign w_in    = adu_bundle_t'(io.adu_exu_bus_i);
    assign w_ready = (r_state == IDLE) | ((r_state == DONE) & io.lsu_ready_i);
    assign w_hs    = io.adu_valid_i & w_ready;

    // The ALU works straight off the incoming bundle so a non-shift result is
    // registered on the handshake edge and valid_o rises one cycle later.
    exu_alu u_alu (
        .i_src1   (w_in.src1),
        .i_src2   (w_in.src2),
        .i_alu_op (w_in.alu_op),
        .o_result (w_alu_result)
    );

`ifdef EXU_ITER_SHIFT_EN
    logic [4:0] r_shcnt;

    // A zero-length shift takes the ALU path (result == src1) and skips SHIFT.
    assign w_iter_start = w_hs & is_shift_op(w_in.alu_op) & (w_in.src2[4:0] != 5'd0);
    assign w_shift_last = (r_shcnt == 5'd1);

    // One-bit shift of the partial result held in r_result
    always_comb begin
        w_shift_step = r_result;
        case (r_bundle.alu_op)
            ALU_SLL: w_shift_step = {r_result[30:0], 1'b0};
            ALU_SRL: w_shift_step = {1'b0, r_result[31:1]};
            ALU_SRA: w_shift_step = {r_result[31], r_result[31:1]};
            default: w_shift_step = r_result;
        endcase
    end

    // Remaining shift count, loaded with shamt and decremented in SHIFT
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shcnt <= 5'd0;
        end else if (w_iter_start) begin
            r_shcnt <= w_in.src2[4:0];
        end else if (r_state == SHIFT) begin
            r_shcnt <= r_shcnt - 5'd1;
        end else begin
            r_shcnt <= r_shcnt;
        end
    end
`else
    assign w_iter_start = 1'b0;
    assign w_shift_last = 1'b1;
    assign w_shift_step = r_result;
`endif

    // SHIFT never overlaps a handshake (ready is low there), so the two
    // sources of a completed result are mutually exclusive.
    assign w_enter_done  = (w_hs & ~w_iter_start) | ((r_state == SHIFT) & w_shift_last);
    assign w_done_result = w_hs ? w_alu_result : w_shift_step;
    assign w_enter_jmp   = w_hs ? w_in.jmp_flag : r_bundle.jmp_flag;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs & w_iter_start) begin
                    w_next_state = SHIFT;
                end else if (w_hs) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (w_shift_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                if (w_hs & w_iter_start) begin
                    w_next_state = SHIFT;
                end else if (w_hs) begin
                    w_next_state = DONE;
                end else if (io.lsu_ready_i) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bundle capture and result/shift accumulator
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bundle <= '0;
            r_result <= 32'd0;
        end else if (w_hs) begin
            r_bundle <= w_in;
            r_result <= w_iter_start ? w_in.src1 : w_alu_result;
        end else if (r_state == SHIFT) begin
            r_bundle <= r_bundle;
            r_result <= w_shift_step;
        end else begin
            r_bundle <= r_bundle;
            r_result <= r_result;
        end
    end

    // Redirect pulse fires only on entry to DONE, so a stalled bundle never re-pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_redirect    <= w_enter_done & w_enter_jmp;
            r_redirect_pc <= w_enter_done ? (w_done_result & 32'hFFFF_FFFE) : r_redirect_pc;
        end
    end

    // Writeback data select: compare flag beats link address beats ALU result
    always_comb begin
        w_wb_data = r_result;
        if (r_bundle.res_from_compare) begin
            w_wb_data = {31'd0, r_bundle.compare_result};
        end else if (r_bundle.jmp_flag) begin
            w_wb_data = r_bundle.snpc;
        end else begin
            w_wb_data = r_result;
        end
    end

    // Result bundle packing; driven only from registers so it is stable while stalled
    always_comb begin
        w_out              = '0;
        w_out.excp_flush   = r_bundle.excp_flush;
        w_out.xret_flush   = r_bundle.xret_flush;
        w_out.break_signal = r_bundle.break_signal;
        w_out.snpc         = r_bundle.snpc;
        w_out.wb_data      = w_wb_data;
        w_out.alu_result   = r_result;
        w_out.rs2_value    = r_bundle.rs2_value;
        w_out.res_from_mem = r_bundle.res_from_mem;
        w_out.res_from_csr = r_bundle.res_from_csr;
        w_out.gr_we        = r_bundle.gr_we;
        w_out.csr_we       = r_bundle.csr_we;
        w_out.mem_re       = r_bundle.mem_re;
        w_out.mem_we       = r_bundle.mem_we;
        w_out.rd           = r_bundle.rd;
        w_out.csr_addr     = r_bundle.csr_addr;
        w_out.csr_wdata    = r_bundle.csr_wdata;
        w_out.csr_value    = r_bundle.csr_value;
    end

    // Bits that intentionally have no consumer: the top of the result struct
    // beyond the bus width, and operands not needed after the result is formed.
    assign w_unused_bits = ^{w_out[LSU_FULL_WIDTH-1:EXU_LSU_BUS_WIDTH],
                             r_bundle.src1, r_bundle.src2, r_bundle.alu_op};

    assign io.adu_ready_o   = w_ready;
    assign io.valid_o       = (r_state == DONE);
    assign io.exu_lsu_bus_o = w_out[EXU_LSU_BUS_WIDTH-1:0];
    assign io.redirect_o    = r_redirect;
    assign io.redirect_pc_o = r_redirect_pc;
endmodule
